// File: rtl/network_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// network_sequencer_pkg
// Shared types and constants for the network sequencer:
//   seq_state_t     - sequencer FSM state encoding
//   SEQ_CNT_W       - width of the phase down-counter
//   *_MIN / *_MAX   - legal ranges of the STREAM_LEN and WARMUP parameters
// -----------------------------------------------------------------------------
package network_sequencer_pkg;

  localparam int SEQ_CNT_W      = 16;

  localparam int STREAM_LEN_MIN = 1;
  localparam int STREAM_LEN_MAX = 65535;
  localparam int WARMUP_MIN     = 0;
  localparam int WARMUP_MAX     = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WARM,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/network_sequencer_counter.sv
// -----------------------------------------------------------------------------
// seq_counter
// Loadable down-counter used to time the WARM and RUN phases.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val this cycle (has priority over en)
//   load_val  - value loaded on load
//   en        - decrement this cycle (saturates at zero)
//   zero      - count is currently zero
// -----------------------------------------------------------------------------
module seq_counter
  import network_sequencer_pkg::*;
#(
  parameter int W = SEQ_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/network_sequencer.sv
// -----------------------------------------------------------------------------
// network_sequencer
// Control sequencer for the stochastic bitstream network. Accepts one request
// (INPUT_SIZE x 32-bit integers, element 0 in the low bits), drives the
// network inputs, steps it through CLEAR -> WARM -> RUN -> CAPTURE, and returns
// the captured OUTPUT_SIZE x 32-bit outputs through a valid/ready handshake.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/ready/data  - request handshake and input vector
//   rsp_valid/ready/data  - response handshake and captured outputs
//   net_input             - held input vector to the network
//   net_n_rst             - active-low network reset (low in IDLE/CLEAR)
//   net_compute           - one-cycle capture strobe at the end of WARM/RUN
//   net_output            - network outputs, sampled in CAPTURE
//   abort                 - only with NETWORK_SEQUENCER_ABORT_EN defined:
//                           abandons a run in CLEAR/WARM/RUN
//   busy                  - not in IDLE
//
// Optional feature macro: NETWORK_SEQUENCER_ABORT_EN
// -----------------------------------------------------------------------------
module network_sequencer
  import network_sequencer_pkg::*;
#(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int STREAM_LEN  = 256,
  parameter int WARMUP      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INPUT_SIZE*32-1:0]  req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUTPUT_SIZE*32-1:0] rsp_data,
  output logic [INPUT_SIZE*32-1:0]  net_input,
  output logic                      net_n_rst,
  output logic                      net_compute,
  input  logic [OUTPUT_SIZE*32-1:0] net_output,
`ifdef NETWORK_SEQUENCER_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy
);

  if (STREAM_LEN < STREAM_LEN_MIN || STREAM_LEN > STREAM_LEN_MAX) begin : g_bad_stream_len
    $error("network_sequencer: STREAM_LEN out of range");
  end
  if (WARMUP < WARMUP_MIN || WARMUP > WARMUP_MAX) begin : g_bad_warmup
    $error("network_sequencer: WARMUP out of range");
  end

  // Counter reload values; the counter runs N-1 .. 0 so a phase lasts N cycles.
  localparam logic [SEQ_CNT_W-1:0] WARM_LOAD = SEQ_CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [SEQ_CNT_W-1:0] RUN_LOAD  = SEQ_CNT_W'(STREAM_LEN - 1);

  seq_state_t state_q, state_d;
  logic [INPUT_SIZE*32-1:0]  net_input_q, net_input_d;
  logic [OUTPUT_SIZE*32-1:0] rsp_data_q,  rsp_data_d;

  logic                 cnt_load;
  logic [SEQ_CNT_W-1:0] cnt_load_val;
  logic                 cnt_en;
  logic                 cnt_zero;
  logic                 compute_raw;
  logic                 abort_hit;

  seq_counter #(.W(SEQ_CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

`ifdef NETWORK_SEQUENCER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    net_input_d  = net_input_q;
    rsp_data_d   = rsp_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = RUN_LOAD;
    cnt_en       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    net_n_rst    = 1'b1;
    compute_raw  = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        net_n_rst = 1'b0;
        if (req_valid) begin
          net_input_d = req_data;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        net_n_rst = 1'b0;
        cnt_load  = 1'b1;
        if (WARMUP > 0) begin
          cnt_load_val = WARM_LOAD;
          state_d      = S_WARM;
        end else begin
          state_d      = S_RUN;
        end
      end
      S_WARM: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          // Flush whatever the integrator accumulated while settling.
          compute_raw = 1'b1;
          cnt_load    = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          compute_raw = 1'b1;
          state_d     = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rsp_data_d = net_output;
        state_d    = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_hit && (state_q == S_CLEAR || state_q == S_WARM || state_q == S_RUN)) begin
      state_d     = S_IDLE;
      compute_raw = 1'b0;
      cnt_load    = 1'b0;
      net_n_rst   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      net_input_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      net_input_q <= net_input_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // A reset landing on the final RUN cycle must not leak a capture strobe.
  assign net_compute = compute_raw & ~rst;
  assign net_input   = net_input_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != S_IDLE);

endmodule
